id_scoreboard: RTL

- Per-register hazard scoreboard beside the ID stage. It adds the load-use and multi-cycle interlocks that plain EX/MEM forwarding cannot resolve.
- It tracks, for every architectural register, how many cycles remain before its pending result becomes forwardable to ID.
- It raises a stall request when the decoded instruction reads a register that is not yet forwardable. It issues the instruction otherwise.
- Latencies are parametrised, so deeper MEM or multiplier pipelines need no RTL change.

---
 rtl/id_scoreboard.sv | 115 +++++++++++
 1 files changed

// File: rtl/id_scoreboard.sv
// Per-register hazard scoreboard beside ID: counts down the cycles until each
// pending result can be forwarded, and holds dependent instructions until then.
module id_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int CNT_W    = 3,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 2,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic              reg1_read_i,
  input  logic [AW-1:0]     reg1_addr_i,
  input  logic              reg2_read_i,
  input  logic [AW-1:0]     reg2_addr_i,
  input  logic              wreg_i,
  input  logic [AW-1:0]     wd_i,
  input  logic [1:0]        lat_class_i,
  input  logic              ext_stall_i,
  input  logic              flush_i,
  output logic              stall_req_o,
  output logic              issue_o,
  output logic [AW-1:0]     hazard_reg_o,
  output logic [NREG-1:0]   busy_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] stall_cnt_d;
  logic              hz1;
  logic              hz2;
  logic              stall_s;
  logic              issue_s;
  logic              upd;
  logic [CNT_W-1:0]  wr_lat;
  logic [AW-1:0]     hazard_s;

  // Hazard lookup against the pre-issue table; register 0 is never consulted.
  always_comb begin
    hz1 = 1'b0;
    hz2 = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      hz1 = hz1 | (reg1_read_i & (int'(reg1_addr_i) == r) & (cnt_q[r] != '0));
      hz2 = hz2 | (reg2_read_i & (int'(reg2_addr_i) == r) & (cnt_q[r] != '0));
    end
    stall_s = ~rst & id_valid_i & ~flush_i & (hz1 | hz2);
    issue_s = ~rst & id_valid_i & ~flush_i & ~ext_stall_i & ~stall_s;
    if (!stall_s) begin
      hazard_s = '0;
    end else if (hz1) begin
      hazard_s = reg1_addr_i;
    end else begin
      hazard_s = reg2_addr_i;
    end
  end

  // Table next state: an issuing writer overrides the countdown of its own entry.
  always_comb begin
    case (lat_class_i)
      2'd0:    wr_lat = '0;
      2'd1:    wr_lat = CNT_W'(LOAD_LAT);
      2'd2:    wr_lat = CNT_W'(MUL_LAT);
      2'd3:    wr_lat = CNT_W'(MUL_LAT);
      default: wr_lat = CNT_W'(MUL_LAT);
    endcase
    upd = issue_s & wreg_i & (wd_i != '0);
    for (int r = 0; r < NREG; r++) begin
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (upd && (int'(wd_i) == r)) begin
        cnt_d[r] = wr_lat;
      end else if (!ext_stall_i && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end else begin
        cnt_d[r] = cnt_q[r];
      end
      busy_d[r] = (cnt_d[r] != '0);
    end
    if (stall_s && !ext_stall_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers; reset drops every pending hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_req_o  = stall_s;
  assign issue_o      = issue_s;
  assign hazard_reg_o = hazard_s;
  assign busy_o       = busy_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
